// File: rtl/gcd_engine.sv
// gcd_engine: iterative binary (Stein) GCD datapath, one reduction step per clock.
// Ports:
//   ACLK        clock, all state on rising edge
//   ARESETN     asynchronous active-low reset
//   in_valid    operand pair valid
//   in_ready    operands accepted (IDLE, not aborting, out of reset)
//   in_a, in_b  operands A and B (W bits)
//   out_valid   result valid, held until out_ready
//   out_ready   consumer accepts result
//   out_gcd     gcd(A,B); gcd(0,x)=x, gcd(0,0)=0
//   out_cycles  STRIP+REDUCE cycles spent on this result, saturating (CW bits)
//   busy        engine is in any state other than IDLE
//   abort       synchronous cancel of the current operation
module gcd_engine #(
    parameter int W  = 32,
    parameter int CW = 16
) (
    input  logic          ACLK,
    input  logic          ARESETN,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [W-1:0]  in_a,
    input  logic [W-1:0]  in_b,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [W-1:0]  out_gcd,
    output logic [CW-1:0] out_cycles,
    output logic          busy,
    input  logic          abort
);
    localparam int KW = $clog2(W) + 1;

    typedef enum logic [1:0] {IDLE, STRIP, REDUCE, DONE} state_t;

    state_t        state, state_nx;
    logic [W-1:0]  a, b, a_nx, b_nx, gcd_nx;
    logic [KW-1:0] k, k_nx;
    logic [CW-1:0] cnt, cnt_nx, cnt_inc, cyc_nx;

    // cycle counter sticks at all-ones instead of wrapping
    assign cnt_inc = (&cnt) ? cnt : cnt + CW'(1);

    // in_ready is gated by ARESETN so it stays low while reset is held
    assign in_ready  = ARESETN && state == IDLE && !abort;
    assign busy      = state != IDLE;
    assign out_valid = state == DONE;

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            state      <= IDLE;
            a          <= '0;
            b          <= '0;
            k          <= '0;
            cnt        <= '0;
            out_gcd    <= '0;
            out_cycles <= '0;
        end else begin
            state      <= state_nx;
            a          <= a_nx;
            b          <= b_nx;
            k          <= k_nx;
            cnt        <= cnt_nx;
            out_gcd    <= gcd_nx;
            out_cycles <= cyc_nx;
        end
    end

    always_comb begin
        state_nx = state;
        a_nx     = a;
        b_nx     = b;
        k_nx     = k;
        cnt_nx   = cnt;
        gcd_nx   = out_gcd;
        cyc_nx   = out_cycles;
        // abort wins over everything; in IDLE it simply blocks acceptance
        if (abort) begin
            state_nx = IDLE;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_nx   = in_a;
                        b_nx   = in_b;
                        k_nx   = '0;
                        cnt_nx = '0;
                        if (in_a == '0) begin
                            gcd_nx   = in_b;
                            cyc_nx   = '0;
                            state_nx = DONE;
                        end else if (in_b == '0) begin
                            gcd_nx   = in_a;
                            cyc_nx   = '0;
                            state_nx = DONE;
                        end else begin
                            state_nx = STRIP;
                        end
                    end
                end
                STRIP: begin
                    cnt_nx = cnt_inc;
                    // remove common factors of two, remembered in k
                    if (!a[0] && !b[0]) begin
                        a_nx = a >> 1;
                        b_nx = b >> 1;
                        k_nx = k + KW'(1);
                    end else begin
                        state_nx = REDUCE;
                    end
                end
                REDUCE: begin
                    cnt_nx = cnt_inc;
                    if (!a[0]) begin
                        a_nx = a >> 1;
                    end else if (!b[0]) begin
                        b_nx = b >> 1;
                    end else if (a == b) begin
                        gcd_nx   = a << k;
                        cyc_nx   = cnt_inc;
                        state_nx = DONE;
                    end else if (a > b) begin
                        a_nx = a - b;
                    end else begin
                        b_nx = b - a;
                    end
                end
                DONE: begin
                    if (out_ready) state_nx = IDLE;
                end
                default: state_nx = IDLE;
            endcase
        end
    end
endmodule
